fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Drives the program-counter register's `newPC`/`enable` load interface and issues instruction-memory reads.
- Returns fetched words, tagged with their PC, to decode through a small FIFO with a valid/ready handshake.
- Handles redirects (branch/jump) at any point, including while a memory read is outstanding.
- Sits between the PC register, instruction memory and the decode stage.

Parameters:
- FIFO_DEPTH, 2, number of instruction buffer entries; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high.
- pc_in  input  32  current value of the PC register.
- pc_en  output  1  load strobe to the PC register (combinational).
- pc_next  output  32  value to load into the PC register (combinational).
- imem_req  output  1  read request, registered; held high until acknowledged.
- imem_addr  output  32  read address = {req_addr[31:2],2'b00}; stable while imem_req is high.
- imem_ack  input  1  one-cycle acknowledge; imem_rdata is valid in the same cycle.
- imem_rdata  input  32  returned instruction word.
- redirect_valid  input  1  one-cycle redirect request.
- redirect_target  input  32  redirect destination PC.
- inst_valid  output  1  FIFO head is valid.
- inst_ready  input  1  decode accepts the head entry.
- inst_data  output  32  head instruction word.
- inst_pc  output  32  PC of the head instruction.

Behaviour:
- Reset (async): state IDLE, imem_req=0, req_addr=0, FIFO empty, inst_valid=0, inst_data=0, inst_pc=0. pc_en is forced to 0 while reset is high.
- States:
  - IDLE: no request outstanding.
  - BUSY: request outstanding; its result will be kept.
  - DROP: request outstanding; its result is stale and will be discarded.
- pc_en = redirect_valid | (state==BUSY & imem_ack).
- pc_next = redirect_valid ? redirect_target : req_addr+4. Redirect always has priority. Addition wraps modulo 2^32.
- IDLE transitions:
  - If !redirect_valid and count<FIFO_DEPTH: req_addr<=pc_in, imem_req<=1, go to BUSY. The request is visible the next cycle.
  - If redirect_valid: stay IDLE; start no request that cycle.
- BUSY transitions:
  - imem_ack & !redirect_valid: push {req_addr, imem_rdata}.
    - If count+1-pop < FIFO_DEPTH: stay BUSY, req_addr<=req_addr+4, imem_req stays 1 (back-to-back, one fetch per cycle with a zero-wait memory).
    - Otherwise: imem_req<=0, go to IDLE.
  - imem_ack & redirect_valid: discard the data, imem_req<=0, go to IDLE.
  - !imem_ack & redirect_valid: go to DROP. imem_req and imem_addr stay unchanged, as the protocol requires a stable address.
- DROP transitions:
  - imem_ack: discard the data, imem_req<=0, go to IDLE.
  - No ack: stay in DROP. A further redirect only updates the PC.
- FIFO:
  - pop = inst_valid & inst_ready.
  - Push and pop in the same cycle are both performed.
  - redirect_valid flushes the FIFO at the same edge; flush overrides push and pop.
- Overflow is impossible: a request only starts when space is reserved, and pops only free space.
- Memory latency is unbounded; ack may arrive the cycle after imem_req rises at the earliest.
- Reset mid-request: the request is abandoned (imem_req drops asynchronously). A late ack arriving in IDLE is ignored.
- imem_ack in IDLE is always ignored.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- With the macro defined:
  - Adds output port misalign_err (1 bit, reset 0).
  - A redirect with target[1:0]!=0 still loads the PC, sets misalign_err=1 (sticky) and enters a HALT state.
  - HALT issues no requests. An outstanding request completes and is discarded.
  - HALT is left only on reset or on an aligned redirect, which clears misalign_err and goes to IDLE (or DROP if a request is still pending).
- Without the macro: no port, no HALT state. Low address bits are silently masked on imem_addr.

Test Plan:
- Reset release, pc_in=0x0, memory acks 1 cycle after req, inst_ready=1 -> imem_addr sequence 0x0,0x4,0x8…; pc_en pulses with each ack (pc_next 0x4,0x8,…); inst_pc/inst_data match in order.
- inst_ready=0, FIFO_DEPTH=2 -> exactly two entries (0x0,0x4) buffered, imem_req falls, pc_in holds 0x8; raise inst_ready -> fetch resumes at 0x8.
- Redirect to 0x100 while BUSY at 0x8 with ack delayed 3 cycles -> pc_next=0x100 pc_en=1, FIFO flushed, imem_addr holds 0x8 until ack, data dropped, next request addr 0x100.
- Redirect to 0x200 in the same cycle as ack for 0xC -> data for 0xC never appears, pc_next=0x200, next request 0x200.
- Assert reset while imem_req=1 at 0x10 -> imem_req=0 and inst_valid=0 immediately; an ack one cycle later produces no push and no pc_en.
- (FETCH_MISALIGN_CHECK_EN) redirect to 0x102 -> misalign_err=1, no requests; redirect to 0x104 -> misalign_err=0, fetch at 0x104.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch controller: PC load, imem read requests and a tagged instruction FIFO.
// Optional: FETCH_MISALIGN_CHECK_EN adds misalign_err and a HALT state.
module fetch_ctrl #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic        pc_en,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic        misalign_err,
`endif
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {IDLE, BUSY, DROP, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;
`endif

    state_t        state;
    logic [31:0]   req_addr;
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;
    logic          ack_hit;
    logic          push;
    logic          pop;

    assign ack_hit     = (state == BUSY) & imem_ack;
    assign push        = ack_hit & ~redirect_valid;
    assign pop         = inst_valid & inst_ready;
    assign count_after = count + CW'(push) - CW'(pop);

    assign pc_en     = ~reset & (redirect_valid | ack_hit);
    assign pc_next   = redirect_valid ? redirect_target : req_addr + 32'd4;
    assign imem_addr = {req_addr[31:2], 2'b00};

    assign inst_valid = (count != '0);
    assign inst_data  = fifo_data[rd_ptr];
    assign inst_pc    = fifo_pc[rd_ptr];

`ifdef FETCH_MISALIGN_CHECK_EN
    logic redir_bad;
    assign redir_bad = redirect_valid & (|redirect_target[1:0]);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            imem_req <= 1'b0;
            req_addr <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_err <= 1'b0;
`endif
        end else begin
`ifdef FETCH_MISALIGN_CHECK_EN
            // A misaligned redirect halts fetch; any pending read still drains.
            if (redir_bad) begin
                misalign_err <= 1'b1;
                state        <= HALT;
                if (imem_ack)
                    imem_req <= 1'b0;
            end else
`endif
            unique case (state)
                IDLE: begin
                    if (!redirect_valid && count < DEPTH) begin
                        req_addr <= pc_in;
                        imem_req <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (imem_ack) begin
                        if (!redirect_valid && count_after < DEPTH) begin
                            req_addr <= req_addr + 32'd4;
                        end else begin
                            imem_req <= 1'b0;
                            state    <= IDLE;
                        end
                    end else if (redirect_valid) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
`ifdef FETCH_MISALIGN_CHECK_EN
                HALT: begin
                    if (imem_ack)
                        imem_req <= 1'b0;
                    if (redirect_valid) begin
                        misalign_err <= 1'b0;
                        state <= (imem_req & ~imem_ack) ? DROP : IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // Redirect flushes the buffer, overriding any push or pop that edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc[i]   <= '0;
                fifo_data[i] <= '0;
            end
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]   <= req_addr;
                fifo_data[wr_ptr] <= imem_rdata;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_after;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl against a queue-based fetch model.
// Model holds the PC register, the outstanding read and the decode buffer.
module tb_fetch_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        pc_en;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    fetch_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .pc_in(pc_in),
        .pc_en(pc_en),
        .pc_next(pc_next),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
`ifdef FETCH_MISALIGN_CHECK_EN
        .misalign_err(misalign_err),
`endif
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_data(inst_data),
        .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    bit          m_out;
    bit          m_stale;
    logic [31:0] m_addr;
    logic [31:0] m_pc;
    int          checks = 0;
    int          errors = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, ~a[17:2]};
    endfunction

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        t = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_FFFF);
`ifdef FETCH_MISALIGN_CHECK_EN
        t[1:0] = 2'b00;
`endif
        return t;
    endfunction

    task automatic model_reset();
        q.delete();
        m_out   = 0;
        m_stale = 0;
        m_addr  = '0;
    endtask

    task automatic step(int ack_pct, int rdy_pct, int red_pct);
        bit          e_en;
        logic [31:0] e_next;
        int          n;
        @(negedge clk);
        imem_ack        = ($urandom_range(99) < ack_pct);
        inst_ready      = ($urandom_range(99) < rdy_pct);
        redirect_valid  = ($urandom_range(99) < red_pct);
        redirect_target = pick_target();
        pc_in           = m_pc;
        imem_rdata      = mem_word({m_addr[31:2], 2'b00});
        e_en   = redirect_valid || (m_out && !m_stale && imem_ack);
        e_next = redirect_valid ? redirect_target : m_addr + 32'd4;
        #1;
        check("imem_req", 32'(imem_req), 32'(m_out));
        if (m_out)
            check("imem_addr", imem_addr, {m_addr[31:2], 2'b00});
        check("inst_valid", 32'(inst_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("inst_pc", inst_pc, q[0].pc);
            check("inst_data", inst_data, q[0].data);
        end
        check("pc_en", 32'(pc_en), 32'(e_en));
        if (e_en)
            check("pc_next", pc_next, e_next);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("misalign_err", 32'(misalign_err), 32'd0);
`endif
        @(posedge clk);
        n = q.size();
        if (redirect_valid) begin
            q.delete();
            if (m_out) begin
                if (imem_ack) m_out = 0;
                else          m_stale = 1;
            end
        end else begin
            if (n != 0 && inst_ready)
                void'(q.pop_front());
            if (m_out && imem_ack) begin
                if (m_stale) begin
                    m_out = 0;
                end else begin
                    q.push_back('{m_addr, mem_word({m_addr[31:2], 2'b00})});
                    if (q.size() < DEPTH) m_addr = m_addr + 32'd4;
                    else                  m_out = 0;
                end
            end else if (!m_out && n < DEPTH) begin
                m_out   = 1;
                m_stale = 0;
                m_addr  = m_pc;
            end
        end
        if (e_en)
            m_pc = e_next;
    endtask

    initial begin
        bit found;
        reset           = 1'b1;
        imem_ack        = 1'b0;
        imem_rdata      = '0;
        inst_ready      = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        pc_in           = '0;
        m_pc            = '0;
        model_reset();
        #3;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_data", inst_data, 32'd0);
        check("rst_pc", inst_pc, 32'd0);
        check("rst_pc_en", 32'(pc_en), 32'd0);
        redirect_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;

        repeat (12) step(100, 100, 0);
        repeat (8)  step(100, 0, 0);
        repeat (8)  step(100, 100, 0);
        repeat (300) step(50, 60, 8);
        repeat (200) step(25, 30, 15);
        repeat (200) step(90, 90, 4);

        for (int r = 0; r < 5; r++) begin
            found = 0;
            for (int k = 0; k < 50 && !found; k++) begin
                if (m_out) found = 1;
                else step(0, 50, 0);
            end
            check("midreq_wait", 32'(found), 32'd1);
            @(negedge clk);
            imem_ack       = 1'b0;
            redirect_valid = 1'b0;
            reset          = 1'b1;
            #1;
            check("midrst_req", 32'(imem_req), 32'd0);
            check("midrst_valid", 32'(inst_valid), 32'd0);
            check("midrst_pc_en", 32'(pc_en), 32'd0);
            model_reset();
            @(posedge clk);
            #2 reset = 1'b0;
            step(100, 100, 0);
            repeat (40) step(60, 70, 10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
